// File: rtl/ntermo_solver.sv
// ntermo_solver: automatic player for the ntermo guessing game.
// Issues a three-digit guess, pulses ENTER, waits HINT_WAIT cycles, samples the
// per-position hints and narrows one 8-bit candidate mask per position until
// every hint reports correct, a mask becomes empty, or MAX_GUESSES is reached.
// Optional build macro NTERMO_SOLVER_GLOBAL_ELIM_EN: a digit reported absent at
// any position (and not reported present/correct anywhere that round) is also
// cleared from every position whose mask is not already a single digit.
module ntermo_solver #(
   parameter int HINT_WAIT   = 4,
   parameter int MAX_GUESSES = 15
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic [1:0] H0,
   input  logic [1:0] H1,
   input  logic [1:0] H2,
   output logic [2:0] N0,
   output logic [2:0] N1,
   output logic [2:0] N2,
   output logic       ENTER,
   output logic       BUSY,
   output logic       DONE,
   output logic       SOLVED,
   output logic [3:0] GUESSES
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_DRIVE, S_WAIT, S_SAMPLE, S_CHECK, S_DONE
   } state_t;

   state_t     r_state;
   logic [7:0] r_mask [3];
   logic [1:0] r_hint [3];
   logic [2:0] r_n    [3];
   logic       r_enter;
   logic       r_busy;
   logic       r_done;
   logic       r_solved;
   logic [3:0] r_guesses;
   logic [7:0] r_wait;

   logic [1:0] w_hint     [3];
   logic [7:0] w_mask_nxt [3];
   logic       w_all_ok;
   logic       w_any_zero;
   logic       w_give_up;
`ifdef NTERMO_SOLVER_GLOBAL_ELIM_EN
   logic [7:0] w_kill;
   logic [7:0] w_keep;
`endif

   // Index of the lowest still-possible digit; an empty mask guesses 0.
   function automatic logic [2:0] f_lowest(input logic [7:0] m);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   function automatic logic f_onehot(input logic [7:0] m);
      return (m != 8'd0) && ((m & (m - 8'd1)) == 8'd0);
   endfunction

   assign w_hint[0] = H0;
   assign w_hint[1] = H1;
   assign w_hint[2] = H2;

   // Next candidate masks from the live hints and the digits currently guessed.
   always_comb begin
      for (int p = 0; p < 3; p++) begin
         w_mask_nxt[p] = r_mask[p];
         case (w_hint[p])
            2'b11:        w_mask_nxt[p] = 8'd1 << r_n[p];
            2'b01, 2'b10: w_mask_nxt[p][r_n[p]] = 1'b0;
            default:      w_mask_nxt[p] = r_mask[p];
         endcase
      end
`ifdef NTERMO_SOLVER_GLOBAL_ELIM_EN
      w_kill = 8'd0;
      w_keep = 8'd0;
      for (int p = 0; p < 3; p++) begin
         if (w_hint[p] == 2'b01) w_kill[r_n[p]] = 1'b1;
         if (w_hint[p][1])       w_keep[r_n[p]] = 1'b1;
      end
      for (int p = 0; p < 3; p++) begin
         if (!f_onehot(w_mask_nxt[p])) w_mask_nxt[p] = w_mask_nxt[p] & ~(w_kill & ~w_keep);
      end
`endif
   end

   assign w_all_ok   = (r_hint[0] == 2'b11) && (r_hint[1] == 2'b11) && (r_hint[2] == 2'b11);
   assign w_any_zero = (r_mask[0] == 8'd0) || (r_mask[1] == 8'd0) || (r_mask[2] == 8'd0);
   assign w_give_up  = (r_guesses == 4'(MAX_GUESSES));

   // Game sequencer: one round is LOAD, DRIVE, HINT_WAIT x WAIT, SAMPLE, CHECK.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state   <= S_IDLE;
         r_enter   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_solved  <= 1'b0;
         r_guesses <= 4'd0;
         r_wait    <= 8'd0;
         for (int p = 0; p < 3; p++) begin
            r_mask[p] <= 8'hFF;
            r_hint[p] <= 2'b00;
            r_n[p]    <= 3'd0;
         end
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (START) begin
                  for (int p = 0; p < 3; p++) r_mask[p] <= 8'hFF;
                  r_guesses <= 4'd0;
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
                  r_solved  <= 1'b0;
                  r_state   <= S_LOAD;
               end
            end
            S_LOAD: begin
               // ENTER and the round count rise together with the new guess.
               for (int p = 0; p < 3; p++) r_n[p] <= f_lowest(r_mask[p]);
               r_enter   <= 1'b1;
               r_guesses <= r_guesses + 4'd1;
               r_state   <= S_DRIVE;
            end
            S_DRIVE: begin
               r_enter <= 1'b0;
               r_wait  <= 8'(HINT_WAIT - 1);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wait == 8'd0) r_state <= S_SAMPLE;
               else                r_wait  <= r_wait - 8'd1;
            end
            S_SAMPLE: begin
               for (int p = 0; p < 3; p++) begin
                  r_hint[p] <= w_hint[p];
                  r_mask[p] <= w_mask_nxt[p];
               end
               r_state <= S_CHECK;
            end
            S_CHECK: begin
               if (w_all_ok) begin
                  r_solved <= 1'b1;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= S_DONE;
               end else if (w_any_zero || w_give_up) begin
                  r_solved <= 1'b0;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= S_DONE;
               end else begin
                  r_state <= S_LOAD;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign N0      = r_n[0];
   assign N1      = r_n[1];
   assign N2      = r_n[2];
   assign ENTER   = r_enter;
   assign BUSY    = r_busy;
   assign DONE    = r_done;
   assign SOLVED  = r_solved;
   assign GUESSES = r_guesses;

endmodule

// File: tb/tb_ntermo_solver.sv
// Bench for ntermo_solver: a game model answers guesses with a 4-cycle hint
// latency, a reference player predicts every guess and the final result, and a
// forked monitor compares the DUT against those predictions as outputs appear.
module tb_ntermo_solver;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       START = 1'b0;
   logic [1:0] H0 = 2'b00, H1 = 2'b00, H2 = 2'b00;
   logic [2:0] N0, N1, N2;
   logic       ENTER, BUSY, DONE, SOLVED;
   logic [3:0] GUESSES;

   logic       START3 = 1'b0;
   logic [1:0] H30, H31, H32;
   logic [2:0] N30, N31, N32;
   logic       ENTER3, BUSY3, DONE3, SOLVED3;
   logic [3:0] GUESSES3;

   int n_tests = 0;
   int n_fail  = 0;

   logic [8:0] sec  = 9'd0;   // {s2,s1,s0}
   int         mode = 0;      // 0 normal, 1 H0 always absent, 2 H2 none in round 1
   int         g_round = 0;
   logic [5:0] dl [4] = '{default: 6'd0};

   logic [12:0] exp_g [$];    // {GUESSES, N2, N1, N0} at each ENTER
   logic [4:0]  exp_r [$];    // {SOLVED, GUESSES} at DONE
   logic [12:0] q3_g  [$];
   logic [4:0]  q3_r  [$];

   logic [12:0] m_g [16];
   int          m_rounds;
   bit          m_solved;

   always #5 CLK = ~CLK;

   ntermo_solver #(.HINT_WAIT(4), .MAX_GUESSES(15)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .H0(H0), .H1(H1), .H2(H2),
      .N0(N0), .N1(N1), .N2(N2), .ENTER(ENTER), .BUSY(BUSY), .DONE(DONE),
      .SOLVED(SOLVED), .GUESSES(GUESSES));

   ntermo_solver #(.HINT_WAIT(4), .MAX_GUESSES(3)) dut3 (
      .CLK(CLK), .RESET(RESET), .START(START3), .H0(H30), .H1(H31), .H2(H32),
      .N0(N30), .N1(N31), .N2(N32), .ENTER(ENTER3), .BUSY(BUSY3), .DONE(DONE3),
      .SOLVED(SOLVED3), .GUESSES(GUESSES3));

   // Game rules: correct, present at some other position, or absent.
   function automatic logic [1:0] game_hint(input logic [8:0] s, input logic [2:0] g,
                                            input int p, input int rnd, input int md);
      if (md == 1 && p == 0) return 2'b01;
      if (md == 2 && p == 2 && rnd == 1) return 2'b00;
      if (s[p*3 +: 3] == g) return 2'b11;
      for (int q = 0; q < 3; q++) if (s[q*3 +: 3] == g) return 2'b10;
      return 2'b01;
   endfunction

   // Second game answers immediately; its secret is 7,7,7.
   assign H30 = game_hint(9'o777, N30, 0, 0, 0);
   assign H31 = game_hint(9'o777, N31, 1, 0, 0);
   assign H32 = game_hint(9'o777, N32, 2, 0, 0);

   // Main game: hints for a guess appear four cycles after it is entered.
   always @(negedge CLK) begin
      if (START && !BUSY) g_round = 0;
      if (ENTER) g_round = g_round + 1;
      {H2, H1, H0} = dl[3];
      dl[3] = dl[2];
      dl[2] = dl[1];
      dl[1] = dl[0];
      dl[0] = {game_hint(sec, N2, 2, g_round, mode),
               game_hint(sec, N1, 1, g_round, mode),
               game_hint(sec, N0, 0, g_round, mode)};
   end

   // Reference player: sets of possible digits per position, lowest one guessed.
   task automatic model(input logic [8:0] s, input int md, input int maxg);
      bit         cand [3][8];
      logic [2:0] g [3];
      logic [1:0] h [3];
      int         cnt;
      bit         all_ok, empty;
      for (int p = 0; p < 3; p++) for (int d = 0; d < 8; d++) cand[p][d] = 1'b1;
      m_solved = 1'b0;
      m_rounds = 0;
      for (int r = 1; r <= maxg; r++) begin
         for (int p = 0; p < 3; p++) begin
            g[p] = 3'd0;
            for (int d = 7; d >= 0; d--) if (cand[p][d]) g[p] = 3'(d);
         end
         m_g[r-1] = {4'(r), g[2], g[1], g[0]};
         for (int p = 0; p < 3; p++) h[p] = game_hint(s, g[p], p, r, md);
         for (int p = 0; p < 3; p++) begin
            if (h[p] == 2'b11) begin
               for (int d = 0; d < 8; d++) cand[p][d] = (d == int'(g[p]));
            end else if (h[p] != 2'b00) begin
               cand[p][g[p]] = 1'b0;
            end
         end
`ifdef NTERMO_SOLVER_GLOBAL_ELIM_EN
         for (int d = 0; d < 8; d++) begin
            bit absent, seen;
            absent = 0; seen = 0;
            for (int p = 0; p < 3; p++) begin
               if (int'(g[p]) == d && h[p] == 2'b01) absent = 1;
               if (int'(g[p]) == d && (h[p] == 2'b10 || h[p] == 2'b11)) seen = 1;
            end
            if (absent && !seen) begin
               for (int p = 0; p < 3; p++) begin
                  cnt = 0;
                  for (int e = 0; e < 8; e++) cnt += int'(cand[p][e]);
                  if (cnt != 1) cand[p][d] = 1'b0;
               end
            end
         end
`endif
         all_ok = (h[0] == 2'b11) && (h[1] == 2'b11) && (h[2] == 2'b11);
         empty = 0;
         for (int p = 0; p < 3; p++) begin
            cnt = 0;
            for (int d = 0; d < 8; d++) cnt += int'(cand[p][d]);
            if (cnt == 0) empty = 1;
         end
         m_rounds = r;
         if (all_ok) begin m_solved = 1'b1; return; end
         if (empty) return;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h", nm, act, req);
      end
   endtask

   task automatic monitor();
      bit pe = 0, pd = 0, pe3 = 0, pd3 = 0;
      logic [12:0] e;
      logic [4:0]  r;
      forever begin
         @(negedge CLK);
         if (RESET) begin
            pe = 0; pd = 0; pe3 = 0; pd3 = 0;
         end else begin
            if (ENTER) begin
               chk("enter_one_cycle", 32'(pe), 32'd0);
               chk("guess_expected", 32'(exp_g.size() != 0), 32'd1);
               if (exp_g.size() != 0) begin
                  e = exp_g.pop_front();
                  chk("guess", 32'({GUESSES, N2, N1, N0}), 32'(e));
               end
            end
            if (DONE && !pd) begin
               chk("result_expected", 32'(exp_r.size() != 0), 32'd1);
               if (exp_r.size() != 0) begin
                  r = exp_r.pop_front();
                  chk("result", 32'({BUSY, SOLVED, GUESSES}), 32'({1'b0, r}));
               end
            end
            if (ENTER3) begin
               chk("enter3_one_cycle", 32'(pe3), 32'd0);
               chk("guess3_expected", 32'(q3_g.size() != 0), 32'd1);
               if (q3_g.size() != 0) begin
                  e = q3_g.pop_front();
                  chk("guess3", 32'({GUESSES3, N32, N31, N30}), 32'(e));
               end
            end
            if (DONE3 && !pd3) begin
               chk("result3_expected", 32'(q3_r.size() != 0), 32'd1);
               if (q3_r.size() != 0) begin
                  r = q3_r.pop_front();
                  chk("result3", 32'({BUSY3, SOLVED3, GUESSES3}), 32'({1'b0, r}));
               end
            end
            pe = ENTER; pd = DONE; pe3 = ENTER3; pd3 = DONE3;
         end
      end
   endtask

   task automatic pulse_start(input bit three);
      @(posedge CLK); #1;
      if (three) START3 = 1'b1; else START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      START3 = 1'b0;
   endtask

   task automatic wait_enter(input int n);
      int seen = 0, k = 0;
      while (seen < n && k < 600) begin
         @(negedge CLK);
         k++;
         if (ENTER) seen++;
      end
      if (seen < n) chk("enter_timeout", 32'(seen), 32'(n));
   endtask

   task automatic wait_done(input bit three, input string nm);
      int k = 0;
      do begin
         @(negedge CLK);
         k++;
      end while (!(three ? DONE3 : DONE) && k < 3000);
      chk({nm, "_done"}, 32'(three ? DONE3 : DONE), 32'd1);
      @(negedge CLK);
      if (three) chk({nm, "_drain"}, 32'(q3_g.size() + q3_r.size()), 32'd0);
      else       chk({nm, "_drain"}, 32'(exp_g.size() + exp_r.size()), 32'd0);
   endtask

   task automatic queue_game(input logic [8:0] s, input int md);
      sec  = s;
      mode = md;
      model(s, md, 15);
      for (int i = 0; i < m_rounds; i++) exp_g.push_back(m_g[i]);
      exp_r.push_back({m_solved, 4'(m_rounds)});
   endtask

   task automatic run_game(input logic [8:0] s, input int md, input bit midstart, input string nm);
      queue_game(s, md);
      pulse_start(0);
      if (midstart) begin
         wait_enter(1);
         @(negedge CLK);
         @(negedge CLK);
         pulse_start(0);
      end
      wait_done(0, nm);
   endtask

   initial begin
      fork
         monitor();
      join_none

      // Reset state
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset_outs", 32'({N2, N1, N0, ENTER, BUSY, DONE, SOLVED, GUESSES}), 32'd0);
      chk("reset_outs3", 32'({N32, N31, N30, ENTER3, BUSY3, DONE3, SOLVED3, GUESSES3}), 32'd0);
      @(posedge CLK); #1;
      RESET = 1'b0;

      // Secret 5,2,7
      run_game({3'd7, 3'd2, 3'd5}, 0, 0, "s527");
`ifndef NTERMO_SOLVER_GLOBAL_ELIM_EN
      chk("s527_final", 32'({SOLVED, GUESSES}), 32'({1'b1, 4'd8}));
`endif

      // Secret 0,0,0 with START-to-ENTER latency
      queue_game(9'd0, 0);
      pulse_start(0);
      @(negedge CLK);
      chk("lat_c1", 32'(ENTER), 32'd0);
      @(negedge CLK);
      chk("lat_c2", 32'(ENTER), 32'd1);
      @(negedge CLK);
      chk("lat_c3", 32'(ENTER), 32'd0);
      wait_done(0, "s000");
      chk("s000_final", 32'({SOLVED, GUESSES}), 32'({1'b1, 4'd1}));

      // Position 0 always reported absent: its mask empties after 8 rounds
      run_game(9'($urandom), 1, 0, "h0abs");
`ifndef NTERMO_SOLVER_GLOBAL_ELIM_EN
      chk("h0abs_final", 32'({SOLVED, GUESSES}), 32'({1'b0, 4'd8}));
`endif

      // H2 reports no hint in round 1
      run_game(9'($urandom), 2, 0, "h2none");

      // START during WAIT is ignored
      run_game({3'd5, 3'd6, 3'd3}, 0, 1, "midstart");

      // Random secrets
      for (int i = 0; i < 6; i++) run_game(9'($urandom), 0, 0, "rand");

      // RESET during WAIT of round 2
      queue_game(9'($urandom) | 9'o001, 0);
      pulse_start(0);
      wait_enter(2);
      @(negedge CLK);
      #1 RESET = 1'b1;
      #1;
      chk("midreset_outs", 32'({N2, N1, N0, ENTER, BUSY, DONE, SOLVED, GUESSES}), 32'd0);
      exp_g.delete();
      exp_r.delete();
      @(posedge CLK); #1;
      chk("midreset_enter", 32'(ENTER), 32'd0);
      RESET = 1'b0;
      run_game(9'($urandom), 0, 0, "after_reset");

      // MAX_GUESSES=3 instance, secret 7,7,7
      model(9'o777, 0, 3);
      for (int i = 0; i < m_rounds; i++) q3_g.push_back(m_g[i]);
      q3_r.push_back({m_solved, 4'(m_rounds)});
      pulse_start(1);
      wait_done(1, "max3");
      chk("max3_final", 32'({SOLVED3, GUESSES3}), 32'({1'b0, 4'd3}));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
